// File: rtl/ysyx_25020047_pkg.sv
// Shared LSU definitions: access size codes, FSM state encoding and the alignment check.
package ysyx_25020047_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_BUS_REQ  = 2'b01,
        ST_BUS_WAIT = 2'b10,
        ST_RESP     = 2'b11
    } lsu_state_e;

    // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            SZ_D:    bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract with sign/zero extension.
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned STRB_W = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]        st_size_i,
    input  logic [OFF_W-1:0]  st_off_i,
    input  logic [XLEN-1:0]   st_wdata_i,
    output logic [XLEN-1:0]   st_wdata_c_o,
    output logic [STRB_W-1:0] st_wstrb_c_o,
    input  logic [1:0]        ld_size_i,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic              ld_unsigned_i,
    input  logic [XLEN-1:0]   ld_rdata_i,
    output logic [XLEN-1:0]   ld_data_c_o
);

    logic [STRB_W-1:0] mask;
    logic [XLEN-1:0]   ld_sh;

    always_comb begin
        case (st_size_i)
            SZ_B:    mask = STRB_W'(8'h01);
            SZ_H:    mask = STRB_W'(8'h03);
            SZ_W:    mask = STRB_W'(8'h0F);
            default: mask = STRB_W'(8'hFF);
        endcase
    end

    assign st_wstrb_c_o = mask << st_off_i;
    assign st_wdata_c_o = st_wdata_i << {st_off_i, 3'b000};
    assign ld_sh        = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_c_o = ld_sh;
        case (ld_size_i)
            SZ_B: begin
                if (ld_unsigned_i) ld_data_c_o = XLEN'(ld_sh[7:0]);
                else               ld_data_c_o = XLEN'($signed(ld_sh[7:0]));
            end
            SZ_H: begin
                if (ld_unsigned_i) ld_data_c_o = XLEN'(ld_sh[15:0]);
                else               ld_data_c_o = XLEN'($signed(ld_sh[15:0]));
            end
            SZ_W: begin
                if (ld_unsigned_i) ld_data_c_o = XLEN'(ld_sh[31:0]);
                else               ld_data_c_o = XLEN'($signed(ld_sh[31:0]));
            end
            default: ld_data_c_o = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu_mc.sv
// Multi-cycle load/store unit: one outstanding access, word-aligned strobed bus request,
// extended load data or store ack, with misalign/illegal-size/bus-error/timeout reporting.
module ysyx_25020047_lsu_mc
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rsp_err
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(XLEN / 8);
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    lsu_state_e          state_q, state_d;
    logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_bad_c, timeout_c, bus_rsp_c;
    logic [XLEN-1:0]     st_wdata_c, ld_data_c;
    logic [STRB_W-1:0]   st_wstrb_c;

    ysyx_25020047_lsu_align #(.XLEN(XLEN)) u_align (
        .st_size_i     (req_size),
        .st_off_i      (req_addr[OFF_W-1:0]),
        .st_wdata_i    (req_wdata),
        .st_wdata_c_o  (st_wdata_c),
        .st_wstrb_c_o  (st_wstrb_c),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (mem_rdata),
        .ld_data_c_o   (ld_data_c)
    );

    assign acc_bad_c = is_misaligned(req_addr[2:0], req_size) || (req_size == SZ_D && XLEN != 64);
    assign timeout_c = (state_q == ST_BUS_WAIT) && (TIMEOUT_CYC != 0)
                       && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // A response is only taken once the request has been (or is being) accepted.
    assign bus_rsp_c = mem_rsp_valid &&
                       ((state_q == ST_BUS_REQ && mem_req_ready) || state_q == ST_BUS_WAIT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_valid) state_d = acc_bad_c ? ST_RESP : ST_BUS_REQ;
            ST_BUS_REQ:  if (mem_req_ready) state_d = bus_rsp_c ? ST_RESP : ST_BUS_WAIT;
            ST_BUS_WAIT: if (bus_rsp_c || timeout_c) state_d = ST_RESP;
            ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d     = (state_d == ST_IDLE);
        rsp_valid_d     = (state_d == ST_RESP);
        mem_req_valid_d = (state_d == ST_BUS_REQ);
        cnt_d           = (state_q == ST_BUS_WAIT && state_d == ST_BUS_WAIT) ? cnt_q + CNT_W'(1) : '0;
        rsp_err_d       = rsp_err_q;
        rsp_rdata_d     = rsp_rdata_q;
        mem_wen_d       = mem_wen_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wstrb_d     = mem_wstrb_q;
        size_d          = size_q;
        uns_d           = uns_q;
        off_d           = off_q;
        if (state_q == ST_IDLE && req_valid) begin
            size_d      = req_size;
            uns_d       = req_unsigned;
            off_d       = req_addr[OFF_W-1:0];
            rsp_err_d   = acc_bad_c;
            rsp_rdata_d = '0;
            if (!acc_bad_c) begin
                mem_wen_d   = req_wen;
                mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                mem_wdata_d = st_wdata_c;
                mem_wstrb_d = req_wen ? st_wstrb_c : '0;
            end
        end else if (bus_rsp_c) begin
            rsp_err_d   = mem_rsp_err;
            rsp_rdata_d = (mem_rsp_err || mem_wen_q) ? '0 : ld_data_c;
        end else if (timeout_c) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            off_q           <= '0;
            cnt_q           <= '0;
        end else begin
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            off_q           <= off_d;
            cnt_q           <= cnt_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_wen       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;

endmodule
